alu_issue_ctrl: RTL and testbench

//   Sequencing initiator for the combinational ALU. Accepts one operation request over a

---
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bundle between the instruction decoder (master) and alu_issue_ctrl (slave).
// ACC_CHAIN_EN adds req_use_acc to the request channel.
interface alu_issue_ctrl_if #(
    parameter int DW = 16,
    parameter int FW = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [FW-1:0]     req_func;
    logic [DW-1:0]     req_a;
    logic [DW-1:0]     req_b;
`ifdef ACC_CHAIN_EN
    logic              req_use_acc;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_acc;
    logic              rsp_carry;
    logic              rsp_err;

`ifdef ACC_CHAIN_EN
    modport master (
        output req_valid, req_func, req_a, req_b, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_acc, rsp_carry, rsp_err
    );
    modport slave (
        input  req_valid, req_func, req_a, req_b, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_acc, rsp_carry, rsp_err
    );
`else
    modport master (
        output req_valid, req_func, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_acc, rsp_carry, rsp_err
    );
    modport slave (
        input  req_valid, req_func, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_acc, rsp_carry, rsp_err
    );
`endif
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one operation to the combinational ALU, waits SETTLE_CYCLES, captures the result and
// holds it on the response port. Optional macro ACC_CHAIN_EN: operand A may come from the last result.
module alu_issue_ctrl #(
    parameter int DW            = 16,
    parameter int FW            = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic [FW-1:0]    alu_func,
    output logic [DW-1:0]    alu_ar,
    output logic [DW-1:0]    alu_br,
    input  logic [2*DW-1:0]  alu_acc,
    input  logic             alu_carry
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam int            CW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [FW-1:0] F_ADD = FW'(1);
    localparam logic [FW-1:0] F_SUB = FW'(2);
    localparam logic [FW-1:0] F_MUL = FW'(3);
    localparam logic [FW-1:0] F_DIV = FW'(4);
    localparam logic [FW-1:0] F_SHR = FW'(9);

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     count;
    logic              out_of_reset;
    logic [2*DW-1:0]   acc_q;
    logic              carry_q;
    logic              err_q;

    logic              accept;
    logic              func_legal;
    logic              div_zero;
    logic              issue;
    logic              settle_done;
    logic [DW-1:0]     a_sel;

    // req_ready stays low through reset and rises on the first edge after release.
    assign bus.req_ready = out_of_reset && (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_acc   = acc_q;
    assign bus.rsp_carry = carry_q;
    assign bus.rsp_err   = err_q;

    assign accept      = bus.req_valid && bus.req_ready;
    assign func_legal  = (bus.req_func >= F_ADD) && (bus.req_func <= F_SHR);
    assign div_zero    = (bus.req_func == F_DIV) && (bus.req_b == '0);
    assign issue       = accept && func_legal && !div_zero;
    assign settle_done = (state == EXEC) && (count == LAST);

`ifdef ACC_CHAIN_EN
    assign a_sel = bus.req_use_acc ? acc_q[DW-1:0] : bus.req_a;
`else
    assign a_sel = bus.req_a;
`endif

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = issue ? EXEC : RESP;
            EXEC:    if (count == LAST) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_of_reset <= 1'b0;
            count        <= '0;
            alu_func     <= '0;
            alu_ar       <= '0;
            alu_br       <= '0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;

            if (state == IDLE && accept) begin
                if (issue) begin
                    alu_func <= bus.req_func;
                    alu_ar   <= a_sel;
                    alu_br   <= bus.req_b;
                    count    <= '0;
                end else begin
                    // Rejected ops never reach the ALU; only the error result is reported.
                    err_q   <= 1'b1;
                    carry_q <= 1'b0;
                    acc_q   <= div_zero ? '1 : '0;
                end
            end

            if (state == EXEC) begin
                count <= count + CW'(1);
            end

            if (settle_done) begin
                acc_q   <= (alu_func == F_MUL || alu_func == F_DIV)
                           ? alu_acc : {{DW{1'b0}}, alu_acc[DW-1:0]};
                carry_q <= (alu_func == F_ADD || alu_func == F_SUB) && alu_carry;
                err_q   <= 1'b0;
            end

            if (state == RESP && bus.rsp_ready) begin
                alu_func <= '0;
                alu_ar   <= '0;
                alu_br   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed requests against a stub ALU, a spec-level
// result model with a per-cycle response compare, and literal expectations for the key cases.
module tb_alu_issue_ctrl;
    localparam int S = 3;

    typedef struct packed {
        logic [31:0] acc;
        logic        carry;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_func;
    logic [15:0] alu_ar;
    logic [15:0] alu_br;
    logic [31:0] alu_acc;
    logic        alu_carry;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] last_acc = '0;

    alu_issue_ctrl_if #(.DW(16), .FW(4)) bus ();

    alu_issue_ctrl #(.DW(16), .FW(4), .SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .alu_func  (alu_func),
        .alu_ar    (alu_ar),
        .alu_br    (alu_br),
        .alu_acc   (alu_acc),
        .alu_carry (alu_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub ALU: unused upper bits and carry carry junk so the capture rules are exercised.
    always_comb begin
        alu_acc   = {16'hDEAD, 16'h0000};
        alu_carry = 1'b1;
        case (alu_func)
            4'd1: {alu_carry, alu_acc[15:0]} = {1'b0, alu_ar} + {1'b0, alu_br};
            4'd2: {alu_carry, alu_acc[15:0]} = {1'b0, alu_ar} - {1'b0, alu_br};
            4'd3: alu_acc = 32'(alu_ar) * 32'(alu_br);
            4'd4: alu_acc = {16'h0000, (alu_br != 0) ? alu_ar / alu_br : 16'hFFFF};
            4'd5: alu_acc[15:0] = alu_ar & alu_br;
            4'd6: alu_acc[15:0] = alu_ar | alu_br;
            4'd7: alu_acc[15:0] = ~alu_ar;
            4'd8: alu_acc[15:0] = alu_ar << alu_br;
            4'd9: alu_acc[15:0] = alu_ar >> alu_br;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                                   input logic use_acc);
        exp_t        e;
        logic [16:0] w;
        logic [15:0] x;
        logic [15:0] r;
        e = '0;
        x = use_acc ? last_acc[15:0] : a;
        if (f == 4'd0 || f > 4'd9) begin
            e.err = 1'b1;
        end else if (f == 4'd4 && b == 16'd0) begin
            e.err = 1'b1;
            e.acc = '1;
        end else begin
            r = '0;
            case (f)
                4'd1: begin w = {1'b0, x} + {1'b0, b}; r = w[15:0]; e.carry = w[16]; end
                4'd2: begin w = {1'b0, x} - {1'b0, b}; r = w[15:0]; e.carry = w[16]; end
                4'd5: r = x & b;
                4'd6: r = x | b;
                4'd7: r = ~x;
                4'd8: r = x << b;
                4'd9: r = x >> b;
                default: ;
            endcase
            e.acc = {16'h0000, r};
            if (f == 4'd3) e.acc = 32'(x) * 32'(b);
            if (f == 4'd4) e.acc = {16'h0000, x / b};
        end
        return e;
    endfunction

    // Every cycle a response is presented it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                check("rsp_acc",   bus.rsp_acc,   exp_q[0].acc);
                check("rsp_carry", bus.rsp_carry, exp_q[0].carry);
                check("rsp_err",   bus.rsp_err,   exp_q[0].err);
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive_req(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                             input logic use_acc);
        bus.req_valid = 1'b1;
        bus.req_func  = f;
        bus.req_a     = a;
        bus.req_b     = b;
`ifdef ACC_CHAIN_EN
        bus.req_use_acc = use_acc;
`else
        if (use_acc) $display("note: chaining requested without ACC_CHAIN_EN");
`endif
    endtask

    task automatic do_op(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic use_acc, input int hold, input logic early_rdy);
        exp_t        e;
        int          edges;
        logic [15:0] a_eff;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1);
        e     = model(f, a, b, use_acc);
        a_eff = use_acc ? last_acc[15:0] : a;
        drive_req(f, a, b, use_acc);
        bus.rsp_ready = early_rdy;
        @(posedge clk);
        exp_q.push_back(e);
        last_acc = e.acc;
        #1;
        if (e.err) begin
            check("err_alu_func", alu_func, 0);
            check("err_alu_ar", alu_ar, 0);
        end else begin
            check("alu_func", alu_func, f);
            check("alu_ar", alu_ar, a_eff);
            check("alu_br", alu_br, b);
        end
        edges = 1;
        while (!bus.rsp_valid && edges < 50) begin
            check("busy_req_ready", bus.req_ready, 0);
            drive_req(4'($urandom_range(1, 9)), 16'($urandom), 16'($urandom), 1'b0);
            @(posedge clk);
            #1;
            edges++;
        end
        bus.req_valid = 1'b0;
        check("latency_edges", edges, e.err ? 1 : S + 1);
        repeat (hold) begin
            check("bp_req_ready", bus.req_ready, 0);
            check("bp_rsp_valid", bus.rsp_valid, 1);
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 0);
        check("post_req_ready", bus.req_ready, 1);
        check("post_alu_func", alu_func, 0);
        check("post_alu_ar", alu_ar, 0);
        check("post_alu_br", alu_br, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_func  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
`ifdef ACC_CHAIN_EN
        bus.req_use_acc = 1'b0;
`endif
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_acc", bus.rsp_acc, 0);
        check("rst_alu_func", alu_func, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_req_ready_low", bus.req_ready, 0);
        @(posedge clk);
        #1 check("release_req_ready_high", bus.req_ready, 1);

        do_op(4'd1, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        check("lit_add_acc", bus.rsp_acc, 32'h0000_0000);
        check("lit_add_carry", bus.rsp_carry, 1);
        check("lit_add_err", bus.rsp_err, 0);

        do_op(4'd3, 16'h1234, 16'h0100, 1'b0, 5, 1'b0);
        check("lit_mul_acc", bus.rsp_acc, 32'h0012_3400);
        check("lit_mul_carry", bus.rsp_carry, 0);

        do_op(4'd4, 16'd100, 16'd7, 1'b0, 0, 1'b0);
        check("lit_div_acc", bus.rsp_acc, 32'd14);

        do_op(4'd4, 16'h0055, 16'h0000, 1'b0, 2, 1'b0);
        check("lit_div0_acc", bus.rsp_acc, 32'hFFFF_FFFF);
        check("lit_div0_err", bus.rsp_err, 1);

        do_op(4'hC, 16'h1111, 16'h2222, 1'b0, 0, 1'b0);
        check("lit_illegal_acc", bus.rsp_acc, 32'h0);
        check("lit_illegal_err", bus.rsp_err, 1);

        do_op(4'd0, 16'h0001, 16'h0001, 1'b0, 0, 1'b1);
        do_op(4'd2, 16'h0003, 16'h0005, 1'b0, 1, 1'b0);
        check("lit_sub_carry", bus.rsp_carry, 1);
        do_op(4'd5, 16'hF0F0, 16'h3C3C, 1'b0, 0, 1'b1);
        check("lit_and_acc", bus.rsp_acc, 32'h0000_3030);
        do_op(4'd6, 16'hF000, 16'h000F, 1'b0, 0, 1'b0);
        do_op(4'd7, 16'h00FF, 16'h0000, 1'b0, 0, 1'b0);
        do_op(4'd8, 16'h00F0, 16'h0004, 1'b0, 0, 1'b1);
        do_op(4'd9, 16'h8000, 16'h000F, 1'b0, 0, 1'b0);
        do_op(4'hF, 16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        do_op(4'd3, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);

        // Reset in the middle of EXEC aborts the operation.
        @(negedge clk);
        drive_req(4'd1, 16'd5, 16'd6, 1'b0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        last_acc = '0;
        #1;
        check("abort_alu_func", alu_func, 0);
        check("abort_alu_ar", alu_ar, 0);
        check("abort_alu_br", alu_br, 0);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        check("abort_rsp_acc", bus.rsp_acc, 0);
        check("abort_rsp_carry", bus.rsp_carry, 0);
        check("abort_rsp_err", bus.rsp_err, 0);
        check("abort_req_ready", bus.req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rerelease_req_ready_low", bus.req_ready, 0);
        @(posedge clk);
        #1 check("rerelease_req_ready_high", bus.req_ready, 1);

        do_op(4'd1, 16'd3, 16'd4, 1'b0, 0, 1'b0);
        check("lit_add7_acc", bus.rsp_acc, 32'd7);
`ifdef ACC_CHAIN_EN
        do_op(4'd8, 16'hFFFF, 16'd2, 1'b1, 0, 1'b0);
        check("lit_chain_acc", bus.rsp_acc, 32'd28);
        do_op(4'd4, 16'h0000, 16'd0, 1'b1, 0, 1'b0);
        check("lit_chain_div0_err", bus.rsp_err, 1);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
